uart_tx_serializer: RTL

- Transmit-path stage directly downstream of the UART Tx frame generator.
- Captures the generator's 11-bit parallel frame on a Send request and shifts it out LSB-first (start bit first) on the serial line, one bit per baud tick.
- Computes the on-air bit count from the frame configuration.
- Reports Busy/Done to the Tx controller.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_serializer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and the frame-length helper for the UART Tx path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} tx_state_e;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE1 = 2'b11;

  localparam int FRAME_W = 11;
  localparam int MAX_LEN = 12;

  // On-air bits: start + data(7/8) + optional parity + stop(1/2), range 9..12.
  function automatic logic [3:0] frame_len(input logic [1:0] parity_type,
                                           input logic       data_length,
                                           input logic       stop_bits);
    logic par_en;
    par_en = (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
    return 4'd9 + {3'b000, data_length} + {3'b000, par_en} + {3'b000, stop_bits};
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Captures an 11-bit frame on Send and shifts it out LSB-first, one bit per BaudTick; DataOut is registered (1 cycle after tick).
// Send is ignored while Busy (not queued); optional idle Break input when UART_TX_BREAK_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int FRAME_W = uart_pkg::FRAME_W,
  parameter int CNT_W   = 4
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               BaudTick,
  input  logic               Send,
  input  logic [FRAME_W-1:0] FrameIn,
  input  logic [1:0]         ParityType,
  input  logic               DataLength,
  input  logic               StopBits,
  output logic               DataOut,
  output logic               Busy,
  output logic               Done
`ifdef UART_TX_BREAK_EN
  ,
  input  logic               Break
`endif
);

  tx_state_e          state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        dout_d = 1'b1;
        busy_d = 1'b0;
`ifdef UART_TX_BREAK_EN
        if (Break) begin
          dout_d = 1'b0;
          busy_d = 1'b1;
        end else
`endif
        if (Send) begin
          shift_d = FrameIn;
          len_d   = CNT_W'(frame_len(ParityType, DataLength, StopBits));
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end

      // A tick coincident with capture is already consumed by IDLE, so the start bit waits here.
      WAIT: begin
        if (BaudTick) begin
          dout_d  = shift_q[0];
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (BaudTick) begin
          cnt_d = cnt_inc;
          if (cnt_inc < len_q) begin
            // Fill with mark so bit positions beyond the frame come out as stop bits.
            shift_d = {1'b1, shift_q[FRAME_W-1:1]};
            dout_d  = shift_q[1];
          end else begin
            dout_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      shift_q <= '1;
      len_q   <= CNT_W'(MAX_LEN);
      cnt_q   <= '0;
      dout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign DataOut = dout_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule
